filter_scan_ctrl: RTL and testbench

- Time-shared controller for the glitch-filter datapath: one compare/count engine serves NCH input channels, scanning round-robin, one channel per clock.
- Each channel has its own stored counter and filtered output level.
- A filtered output changes only after the new input level has been seen on THRESH consecutive scans of that channel.
- Sits between raw level inputs and downstream logic; threshold is runtime-configurable and reports each output change as an event.

---
 rtl/filter_scan_ctrl.sv | 114 +++++++++++
 tb/tb_filter_scan_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_scan_ctrl.sv
// Time-shared glitch filter: one compare/count engine scans NCH channels round-robin,
// keeping a per-channel counter and filtered level, and reports each output change.
module filter_scan_ctrl #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 4,
  parameter int DEF_THRESH = 3,
  parameter int INIT_LVL   = 1,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [NCH-1:0]   sig_in,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic [NCH-1:0]   sig_out,
  output logic             chg_valid,
  output logic [CW-1:0]    chg_ch,
  output logic             chg_level,
  output logic [CW-1:0]    scan_ch,
  output logic             wrap
);

  logic [CW-1:0]    scan_q, scan_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   out_q, out_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] pend_thr_q, pend_thr_d;
  logic             pend_q, pend_d;
  logic             chg_valid_q, chg_valid_d;
  logic [CW-1:0]    chg_ch_q, chg_ch_d;
  logic             chg_level_q, chg_level_d;

  logic [CNT_W-1:0] t_eff;
  logic             at_last;
  logic             samp;

  always_comb begin
    scan_d      = scan_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    thr_d       = thr_q;
    pend_thr_d  = pend_thr_q;
    pend_d      = pend_q;
    chg_valid_d = 1'b0;
    chg_ch_d    = chg_ch_q;
    chg_level_d = chg_level_q;

    // A zero threshold behaves as one: any differing sample flips the output.
    t_eff   = (thr_q == '0) ? CNT_W'(1) : thr_q;
    at_last = (scan_q == CW'(NCH - 1));
    samp    = sig_in[scan_q];

    if (enable) begin
      scan_d = at_last ? '0 : scan_q + 1'b1;
      if (samp == out_q[scan_q]) begin
        cnt_d[scan_q] = '0;
      end else if (cnt_q[scan_q] == t_eff - 1'b1) begin
        out_d[scan_q] = samp;
        cnt_d[scan_q] = '0;
        chg_valid_d   = 1'b1;
        chg_ch_d      = scan_q;
        chg_level_d   = samp;
      end else begin
        cnt_d[scan_q] = cnt_q[scan_q] + 1'b1;
      end

      // A new threshold only takes effect between sweeps, with all counts restarted.
      if (at_last && pend_q) begin
        thr_d  = pend_thr_q;
        pend_d = 1'b0;
        for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
      end
    end

    if (cfg_we) begin
      pend_thr_d = cfg_thresh;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_q      <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      out_q       <= {NCH{INIT_LVL[0]}};
      thr_q       <= CNT_W'(DEF_THRESH);
      pend_thr_q  <= '0;
      pend_q      <= 1'b0;
      chg_valid_q <= 1'b0;
      chg_ch_q    <= '0;
      chg_level_q <= 1'b0;
    end else begin
      scan_q      <= scan_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      thr_q       <= thr_d;
      pend_thr_q  <= pend_thr_d;
      pend_q      <= pend_d;
      chg_valid_q <= chg_valid_d;
      chg_ch_q    <= chg_ch_d;
      chg_level_q <= chg_level_d;
    end
  end

  assign sig_out   = out_q;
  assign chg_valid = chg_valid_q;
  assign chg_ch    = chg_ch_q;
  assign chg_level = chg_level_q;
  assign scan_ch   = scan_q;
  assign wrap      = enable & at_last;

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Directed bench for filter_scan_ctrl: threshold timing, glitch rejection,
// deferred threshold load, scan freeze and asynchronous reset.
module tb_filter_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] sig_in;
  logic       cfg_we;
  logic [3:0] cfg_thresh;
  logic [3:0] sig_out;
  logic       chg_valid;
  logic [1:0] chg_ch;
  logic       chg_level;
  logic [1:0] scan_ch;
  logic       wrap;

  int checks   = 0;
  int failures = 0;
  int exp_scan = 0;

  filter_scan_ctrl #(
    .NCH(4), .CNT_W(4), .DEF_THRESH(3), .INIT_LVL(1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .sig_in     (sig_in),
    .cfg_we     (cfg_we),
    .cfg_thresh (cfg_thresh),
    .sig_out    (sig_out),
    .chg_valid  (chg_valid),
    .chg_ch     (chg_ch),
    .chg_level  (chg_level),
    .scan_ch    (scan_ch),
    .wrap       (wrap)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock; the scan pointer model advances only while enabled.
  task automatic tick();
    @(posedge clock);
    if (enable && reset) exp_scan = (exp_scan + 1) % 4;
    #1;
    chk("scan_ch", {6'b0, scan_ch}, exp_scan[7:0]);
    chk("wrap", {7'b0, wrap}, {7'b0, (enable && exp_scan == 3)});
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      tick();
      chk("no_chg", {7'b0, chg_valid}, 8'h0);
    end
  endtask

  // Step until the next edge will sample channel ch.
  task automatic advance_to(input int ch);
    int guard = 0;
    while (exp_scan != ch && guard < 8) begin
      quiet(1);
      guard++;
    end
    chk("advance_bound", guard[7:0] < 8 ? 8'h1 : 8'h0, 8'h1);
  endtask

  task automatic chk_chg(input string tag, input logic [1:0] ch, input logic lvl);
    chk({tag, "_valid"}, {7'b0, chg_valid}, 8'h1);
    chk({tag, "_ch"}, {6'b0, chg_ch}, {6'b0, ch});
    chk({tag, "_level"}, {7'b0, chg_level}, {7'b0, lvl});
  endtask

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    cfg_we     = 1'b0;
    cfg_thresh = 4'd0;
    sig_in     = 4'b1111;
    repeat (2) @(posedge clock);
    #3;
    chk("rst_sig_out", {4'b0, sig_out}, 8'h0f);
    chk("rst_scan", {6'b0, scan_ch}, 8'h0);
    chk("rst_chg_valid", {7'b0, chg_valid}, 8'h0);
    chk("rst_chg_ch", {6'b0, chg_ch}, 8'h0);
    chk("rst_chg_level", {7'b0, chg_level}, 8'h0);
    chk("rst_wrap", {7'b0, wrap}, 8'h0);
    reset = 1'b1;

    // ch2 low: flips on its third scan, edge 11 after release.
    enable = 1'b1;
    sig_in = 4'b1011;
    quiet(10);
    chk("b_before", {4'b0, sig_out}, 8'h0f);
    tick();
    chk("b_after", {4'b0, sig_out}, 8'h0b);
    chk_chg("b_chg", 2'd2, 1'b0);
    quiet(1);
    chk("b_hold_ch", {6'b0, chg_ch}, 8'h2);
    chk("b_hold_lvl", {7'b0, chg_level}, 8'h0);

    // ch1 glitch for two scans, recovery, then two more: counter must have restarted.
    sig_in = 4'b1001;
    advance_to(1); quiet(1);
    advance_to(1); quiet(1);
    sig_in = 4'b1011;
    advance_to(1); quiet(1);
    sig_in = 4'b1001;
    advance_to(1); quiet(1);
    advance_to(1); quiet(1);
    chk("c_sig_out", {4'b0, sig_out}, 8'h0b);
    sig_in = 4'b1011;
    advance_to(1); quiet(1);

    // Threshold 1 loaded mid-sweep: ch3 counts under old T, flips after the wrap.
    advance_to(2);
    cfg_we     = 1'b1;
    cfg_thresh = 4'd1;
    sig_in     = 4'b0011;
    quiet(1);
    cfg_we = 1'b0;
    quiet(1);
    chk("d_old_sweep", {4'b0, sig_out}, 8'h0b);
    quiet(3);
    tick();
    chk("d_new_sweep", {4'b0, sig_out}, 8'h03);
    chk_chg("d_chg", 2'd3, 1'b0);

    // Back to T=3, then freeze the scan with ch2 two scans into its count.
    cfg_we     = 1'b1;
    cfg_thresh = 4'd3;
    quiet(1);
    cfg_we = 1'b0;
    advance_to(3); quiet(1);
    sig_in = 4'b0111;
    advance_to(2); quiet(1);
    advance_to(2); quiet(1);
    enable = 1'b0;
    quiet(10);
    chk("e_frozen", {4'b0, sig_out}, 8'h03);
    enable = 1'b1;
    advance_to(2);
    tick();
    chk("e_resume", {4'b0, sig_out}, 8'h07);
    chk_chg("e_chg", 2'd2, 1'b1);

    // Threshold 0 strobed on the wrap edge: stays pending one more sweep.
    cfg_we     = 1'b1;
    cfg_thresh = 4'd0;
    quiet(1);
    cfg_we = 1'b0;
    sig_in = 4'b0110;
    quiet(1);
    advance_to(3); quiet(1);
    tick();
    chk("f_t0_ch0", {4'b0, sig_out}, 8'h06);
    chk_chg("f_chg0", 2'd0, 1'b0);
    sig_in = 4'b1110;
    advance_to(3);
    tick();
    chk("f_t0_ch3", {4'b0, sig_out}, 8'h0e);
    chk_chg("f_chg3", 2'd3, 1'b1);

    // Asynchronous reset mid-scan with sig_out[2]=0.
    sig_in = 4'b1010;
    advance_to(2);
    tick();
    chk("g_pre", {4'b0, sig_out}, 8'h0a);
    #2;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    chk("g_sig_out", {4'b0, sig_out}, 8'h0f);
    chk("g_scan", {6'b0, scan_ch}, 8'h0);
    chk("g_chg_valid", {7'b0, chg_valid}, 8'h0);
    chk("g_chg_ch", {6'b0, chg_ch}, 8'h0);
    chk("g_chg_level", {7'b0, chg_level}, 8'h0);
    exp_scan = 0;
    sig_in   = 4'b1011;
    repeat (3) @(posedge clock);
    #3;
    reset  = 1'b1;
    enable = 1'b1;
    quiet(10);
    chk("g_before", {4'b0, sig_out}, 8'h0f);
    tick();
    chk("g_after", {4'b0, sig_out}, 8'h0b);
    chk_chg("g_chg", 2'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
